// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch (one read per 4 pixels) has priority, and a write
// FIFO drains on all other cycles. Define VGA_FB_STATS_EN to add the frame_writes statistic.
module vga_fb_arbiter #(
    parameter int unsigned H_DISPLAY  = 800,
    parameter int unsigned V_DISPLAY  = 600,
    parameter int unsigned PIX_BITS   = 8,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned DW = 4 * PIX_BITS,
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              blank_n,
    input  logic              hSync_n,
    input  logic              vSync_n,
    input  logic [10:0]       nextX,
    input  logic [9:0]        nextY,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [PIX_BITS-1:0] pixel,
    output logic              pix_blank_n,
    output logic              pix_hSync_n,
    output logic              pix_vSync_n,
    output logic [LW-1:0]     fifo_level
`ifdef VGA_FB_STATS_EN
    ,
    output logic [31:0]       frame_writes
`endif
);

    localparam int unsigned PW       = $clog2(FIFO_DEPTH);
    localparam int unsigned NumWords = H_DISPLAY * V_DISPLAY / 4;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DW-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]     count_q, count_d;

    logic              fetch, push, pop, head_in_range;
    logic [31:0]       fetch_addr_full;
    logic [ADDR_W-1:0] head_addr;
    logic [DW-1:0]     head_data;

    assign fetch           = blank_n && (nextX[1:0] == 2'b00);
    assign fetch_addr_full = 32'(nextY) * (H_DISPLAY / 4) + 32'(nextX[10:2]);

    // wr_ready uses the registered count, so a same-cycle pop never frees a slot early.
    assign wr_ready   = !Reset && (count_q < LW'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign pop        = !Reset && !fetch && (count_q != '0);
    assign fifo_level = count_q;

    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign head_in_range = (32'(head_addr) < NumWords);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_err    = 1'b0;
        if (!Reset) begin
            if (fetch) begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr_full[ADDR_W-1:0];
            end else if (pop) begin
                if (head_in_range) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = head_addr;
                    mem_wdata = head_data;
                end else begin
                    wr_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (!push && pop) begin
            count_d = count_q - LW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pixel path: lane select, blank and syncs travel two stages to meet the fetched word.
    logic                rd_pend_q;
    logic [DW-1:0]       word_q;
    logic [1:0]          lane1_q, lane2_q;
    logic                blank1_q, blank2_q;
    logic                hs1_q, hs2_q, vs1_q, vs2_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_pend_q <= 1'b0;
            word_q    <= '0;
            lane1_q   <= '0;
            lane2_q   <= '0;
            blank1_q  <= 1'b0;
            blank2_q  <= 1'b0;
            hs1_q     <= 1'b1;
            hs2_q     <= 1'b1;
            vs1_q     <= 1'b1;
            vs2_q     <= 1'b1;
        end else begin
            rd_pend_q <= mem_en && !mem_we;
            if (rd_pend_q) word_q <= mem_rdata;
            lane1_q   <= nextX[1:0];
            lane2_q   <= lane1_q;
            blank1_q  <= blank_n;
            blank2_q  <= blank1_q;
            hs1_q     <= hSync_n;
            hs2_q     <= hs1_q;
            vs1_q     <= vSync_n;
            vs2_q     <= vs1_q;
        end
    end

    always_comb begin
        pixel = '0;
        if (blank2_q) pixel = word_q[32'(lane2_q) * PIX_BITS +: PIX_BITS];
    end

    assign pix_blank_n = blank2_q;
    assign pix_hSync_n = hs2_q;
    assign pix_vSync_n = vs2_q;

`ifdef VGA_FB_STATS_EN
    logic        vsync_q;
    logic [31:0] wr_count_q;
    logic        commit;

    assign commit = mem_en && mem_we;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vsync_q      <= 1'b1;
            wr_count_q   <= '0;
            frame_writes <= '0;
        end else begin
            vsync_q <= vSync_n;
            if (vsync_q && !vSync_n) begin
                frame_writes <= wr_count_q;
                wr_count_q   <= commit ? 32'd1 : 32'd0;
            end else if (commit) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end
`else
    // No write statistics in this build.
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based behavioural model of arbitration and pixel timing.
module tb_vga_fb_arbiter;

    localparam int H     = 800;
    localparam int V     = 600;
    localparam int WORDS = H * V / 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        blank_n = 1'b0, hSync_n = 1'b1, vSync_n = 1'b1;
    logic [10:0] nextX = '0;
    logic [9:0]  nextY = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [16:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        wr_err, mem_en, mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  pixel;
    logic        pix_blank_n, pix_hSync_n, pix_vSync_n;
    logic [3:0]  fifo_level;
`ifdef VGA_FB_STATS_EN
    logic [31:0] frame_writes;
`endif

    vga_fb_arbiter dut (
        .Clock(Clock), .Reset(Reset), .blank_n(blank_n), .hSync_n(hSync_n),
        .vSync_n(vSync_n), .nextX(nextX), .nextY(nextY), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pixel(pixel), .pix_blank_n(pix_blank_n),
        .pix_hSync_n(pix_hSync_n), .pix_vSync_n(pix_vSync_n), .fifo_level(fifo_level)
`ifdef VGA_FB_STATS_EN
        , .frame_writes(frame_writes)
`endif
    );

    always #5 Clock = ~Clock;

    // ---------------- behavioural model ----------------
    logic [31:0] ram [int];
    logic [16:0] q_addr [$];
    logic [31:0] q_data [$];
    logic [31:0] last_word;
    logic [7:0]  pd [2];
    bit          pbk [2], phs [2], pvs [2];
    bit          m_fetch, m_ready, m_pop;
    int          m_faddr;
    logic [67:0] exp_vec;
    logic [67:0] act_vec;
    int          checks = 0, errors = 0, cyc = 0;

    assign act_vec = {mem_en, mem_en & mem_we, mem_en ? mem_addr : 17'd0,
                      (mem_en & mem_we) ? mem_wdata : 32'd0, wr_err, wr_ready, fifo_level,
                      pixel, pix_blank_n, pix_hSync_n, pix_vSync_n};

    function automatic logic [31:0] ram_rd(input int a);
        logic [31:0] v;
        v = a;
        return ram.exists(a) ? ram[a] : {v[15:0] ^ 16'h5a5a, v[15:0]};
    endfunction

    always @(posedge Clock) if (mem_en && !mem_we) mem_rdata <= ram_rd(int'(mem_addr));

    task automatic model_reset();
        q_addr.delete();
        q_data.delete();
        last_word = '0;
        for (int i = 0; i < 2; i++) begin
            pd[i] = '0; pbk[i] = 0; phs[i] = 1; pvs[i] = 1;
        end
    endtask

    task automatic model_eval();
        bit          en, we, err;
        logic [16:0] ea;
        logic [31:0] ewd;
        en = 0; we = 0; err = 0; ea = '0; ewd = '0;
        if (Reset) model_reset();
        m_fetch = blank_n && (int'(nextX) % 4 == 0);
        m_faddr = int'(nextY) * (H / 4) + int'(nextX) / 4;
        m_ready = !Reset && (q_addr.size() < 8);
        m_pop   = !Reset && !m_fetch && (q_addr.size() > 0);
        if (!Reset && m_fetch) begin
            en = 1; ea = 17'(m_faddr);
        end else if (m_pop) begin
            if (int'(q_addr[0]) < WORDS) begin
                en = 1; we = 1; ea = q_addr[0]; ewd = q_data[0];
            end else begin
                err = 1;
            end
        end
        exp_vec = {en, we, ea, ewd, err, m_ready, 4'(q_addr.size()), pd[1], pbk[1],
                   phs[1], pvs[1]};
    endtask

    task automatic model_commit();
        logic [31:0] w;
        logic [7:0]  cur;
        w = m_fetch ? ram_rd(m_faddr) : last_word;
        if (m_fetch) last_word = w;
        cur = blank_n ? w[8 * (int'(nextX) % 4) +: 8] : 8'd0;
        pd[1] = pd[0]; pbk[1] = pbk[0]; phs[1] = phs[0]; pvs[1] = pvs[0];
        pd[0] = cur;   pbk[0] = blank_n; phs[0] = hSync_n; pvs[0] = vSync_n;
        if (m_pop) begin
            if (int'(q_addr[0]) < WORDS) ram[int'(q_addr[0])] = q_data[0];
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (wr_valid && m_ready) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
    endtask

    task automatic drive(input bit rst, input bit b, input bit hs, input bit vs, input int x,
                         input int y, input bit wv, input int wa, input logic [31:0] wd);
        @(negedge Clock);
        Reset = rst; blank_n = b; hSync_n = hs; vSync_n = vs;
        nextX = 11'(x); nextY = 10'(y);
        wr_valid = wv; wr_addr = 17'(wa); wr_data = wd;
        #1;
        model_eval();
        cyc++;
    endtask

    task automatic finish_cycle();
        @(posedge Clock);
        if (!Reset) model_commit();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 1, 1, 9, 32'hdead_beef);
            checks++;
            if (act_vec !== exp_vec || {mem_we, mem_addr, mem_wdata} !== '0) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            finish_cycle();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            finish_cycle();
        end
    endtask

    task automatic test_display_line();
        logic [7:0] lit [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        ram[200] = 32'h4433_2211;
        ram[201] = 32'h8877_6655;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(0, 1, 1, 1, i, 1, 0, 0, 0);
            else       drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL line cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (i == 0 || i == 4) begin
                checks++;
                if (!(mem_en && !mem_we && mem_addr == 17'(200 + i / 4))) begin
                    errors++;
                    $display("FAIL line_read x=%0d got en=%b we=%b addr=%0d exp addr=%0d",
                             i, mem_en, mem_we, mem_addr, 200 + i / 4);
                end
            end
            if (i >= 2) begin
                checks++;
                if (pixel !== lit[i-2]) begin
                    errors++;
                    $display("FAIL line_pixel x=%0d got=%h exp=%h", i - 2, pixel, lit[i-2]);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_preload_writes();
        int seen [$];
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 1, 1, i, 3, i < 3, 5 + i, $urandom);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL preload cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (mem_en && mem_we) begin
                seen.push_back(int'(mem_addr));
                checks++;
                if (nextX[1:0] == 2'b00) begin
                    errors++;
                    $display("FAIL preload_slot x=%0d got write on fetch slot exp none", i);
                end
            end
            finish_cycle();
        end
        checks++;
        if (seen.size() != 3 || seen[0] != 5 || seen[1] != 6 || seen[2] != 7 ||
            fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL preload_order got n=%0d level=%0d exp n=3 order 5,6,7 level=0",
                     seen.size(), fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dat [9];
        int sent = 0;
        bit acc;
        for (int k = 0; k < 9; k++) dat[k] = $urandom;
        for (int i = 0; i < 60; i++) begin
            drive(0, i < 10, 1, 1, 0, 0, sent < 9, 100 + sent, dat[sent % 9]);
            acc = (sent < 9) && m_ready;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (i == 8) begin
                checks++;
                if (wr_ready !== 1'b0 || fifo_level !== 4'd8) begin
                    errors++;
                    $display("FAIL b2b_full got ready=%b level=%0d exp ready=0 level=8",
                             wr_ready, fifo_level);
                end
            end
            finish_cycle();
            if (acc) sent++;
            if (i >= 10 && sent == 9 && q_addr.size() == 0) break;
        end
        checks++;
        if (sent != 9 || ram_rd(108) !== dat[8] || ram_rd(100) !== dat[0]) begin
            errors++;
            $display("FAIL b2b_done got sent=%0d ram108=%h exp sent=9 ram108=%h",
                     sent, ram_rd(108), dat[8]);
        end
    endtask

    task automatic test_err();
        int pulses = 0;
        int addrs [3] = '{10, WORDS, 11};
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 1, 0, 0, i < 3, addrs[i % 3], $urandom);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL err cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (wr_err) pulses++;
            finish_cycle();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL err_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_random();
        bit          p_valid = 0, acc, b;
        int          p_addr = 0;
        logic [31:0] p_data = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p_valid && $urandom_range(0, 1) == 1) begin
                p_valid = 1;
                p_addr  = ($urandom_range(0, 7) == 0) ? WORDS + int'($urandom_range(0, 999))
                                                       : int'($urandom_range(0, WORDS - 1));
                p_data  = $urandom;
            end
            b = ($urandom_range(0, 3) != 0);
            drive(0, b, 1'($urandom), 1'($urandom), b ? int'($urandom_range(0, H - 1)) : 0,
                  b ? int'($urandom_range(0, V - 1)) : 0, p_valid, p_addr, p_data);
            acc = p_valid && m_ready;
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            finish_cycle();
            if (acc) p_valid = 0;
        end
    endtask

    task automatic test_reset_mid_drain();
        int stray = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, i < 5, 1, 1, 0, 0, i < 5, 300 + i, $urandom);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL rmd_fill cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            finish_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
            checks++;
            if (fifo_level !== 4'd0 || mem_en !== 1'b0 || act_vec !== exp_vec) begin
                errors++;
                $display("FAIL rmd_reset got level=%0d en=%b exp level=0 en=0",
                         fifo_level, mem_en);
            end
            finish_cycle();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++;
                $display("FAIL rmd_after cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
            end
            if (mem_en) stray++;
            finish_cycle();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rmd_stale got=%0d accesses exp=0", stray);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_display_line();
        test_preload_writes();
        test_back_to_back();
        test_err();
        test_random();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got no completion exp finish within 1ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Schedules a single-port framebuffer RAM between two requesters: display fetch, driven by the VGA timing generator's nextX/nextY/blank_n, and a pixel writer such as a drawing engine or CPU.
- Each RAM word packs 4 pixels, so display fetch needs 1 access per 4 active pixels. All other cycles drain a write FIFO.
- Delivers pixel data and delayed blank/sync signals, aligned, to the DAC side.

Parameters:
- H_DISPLAY, 800, active pixels per line; must be a multiple of 4.
- V_DISPLAY, 600, active lines.
- PIX_BITS, 8, bits per pixel; word width DW = 4*PIX_BITS.
- ADDR_W, 17, RAM word address width.
- FIFO_DEPTH, 8, write FIFO entries; power of 2, at least 2.

Ports:
- Clock  in  1  system/pixel clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- blank_n  in  1  from timing generator; 1 = active pixel.
- hSync_n  in  1  from timing generator.
- vSync_n  in  1  from timing generator.
- nextX  in  11  pixel column, 0 in blanking.
- nextY  in  10  pixel row, 0 in blanking.
- wr_valid  in  1  writer request.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ADDR_W  word address.
- wr_data  in  DW  4 packed pixels; lane 0 = bits [PIX_BITS-1:0] = leftmost pixel.
- wr_err  out  1  one-cycle pulse: popped entry had out-of-range address and was dropped.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, valid the cycle after the read.
- pixel  out  PIX_BITS  pixel to DAC.
- pix_blank_n  out  1  blank_n delayed 2 cycles.
- pix_hSync_n  out  1  hSync_n delayed 2 cycles.
- pix_vSync_n  out  1  vSync_n delayed 2 cycles.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: FIFO empty, fifo_level=0, wr_ready=0 during reset and 1 after, wr_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pixel=0, pix_blank_n=0, pix_hSync_n=1, pix_vSync_n=1, word register=0.
- Reset mid-operation drops all FIFO contents and any in-flight read. No RAM access occurs in the reset cycle.
- RAM model is synchronous: the address is sampled at the edge ending cycle t; mem_rdata is valid throughout cycle t+1.
- mem_* outputs are combinational from registered state and current inputs.
- Display fetch (fetch cycle):
  - Condition: blank_n=1 and nextX[1:0]=0.
  - Drive mem_en=1, mem_we=0, mem_addr = nextY*(H_DISPLAY/4) + nextX[10:2], computed at full width and truncated to ADDR_W.
  - Display fetch has absolute priority over writes.
- Write drain:
  - Condition: any non-fetch cycle with FIFO non-empty.
  - Pop the head entry. If its addr < (H_DISPLAY*V_DISPLAY)/4, drive mem_en=1, mem_we=1, mem_addr/mem_wdata from the entry.
  - Otherwise issue no RAM access and pulse wr_err for that cycle.
  - At most 1 pop per cycle.
- FIFO rules:
  - Push when wr_valid & wr_ready.
  - wr_ready = (fifo_level < FIFO_DEPTH), using the registered count. A pop in the same cycle does not raise wr_ready when full.
  - No bypass: a pushed entry is drained no earlier than the next cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Order is strictly FIFO.
- Pixel path:
  - The word register latches mem_rdata at the end of the cycle after each fetch.
  - Pixel for coordinate (x,y) presented in cycle t appears on pixel in cycle t+2: lane x[1:0] of the word register.
  - x[1:0] and blank_n are carried through a 2-stage pipeline.
  - pixel = 0 whenever pix_blank_n = 0.
  - Sync signals are delayed identically, so pixel, pix_blank_n, pix_hSync_n and pix_vSync_n remain mutually aligned.
- Bandwidth: during active video, 3 of every 4 cycles are available for writes; during blanking, every cycle is available.
- Boundaries:
  - Fetch at x=H_DISPLAY-4 is the last fetch on a line.
  - No fetch occurs in blanking, even though nextX=0 there.
  - Address wraps only by truncation; with defaults the maximum address is 119999, so no wrap occurs.

Optional Feature:
- Macro: VGA_FB_STATS_EN.
- When defined, adds output frame_writes (32 bits, reset 0) and an internal counter of RAM writes actually committed (mem_we=1).
- On each vSync_n falling edge (detected with a registered copy of vSync_n), frame_writes is loaded with the counter value. The counter then restarts at 0, or at 1 if a write commits in that same cycle.
- Dropped (out-of-range) entries are not counted.
- When the macro is undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then idle timing stream → after reset wr_ready=1, fifo_level=0, mem_en=0, pixel=0, pix_hSync_n/pix_vSync_n track inputs with 2-cycle delay.
- Active line y=1, x=0..7 (blank_n=1) → reads at mem_addr 200 (cycle x=0) and 201 (cycle x=4) only. With mem_rdata=32'h44332211 then 32'h88776655, pixel = 11,22,33,44,55,66,77,88 starting 2 cycles after x=0.
- Preload 3 writes (addr 5,6,7) during active video at x=0 → each write is issued on a non-fetch cycle, never on a cycle with nextX[1:0]=0. Writes reach RAM in order 5,6,7 and fifo_level returns to 0.
- Push 8 writes back-to-back during a fetch cycle with the FIFO empty → wr_ready falls after the 8th push; a 9th wr_valid is held off until the first pop completes. No data is lost or reordered.
- Write with addr 120000 → popped with no RAM access, wr_err pulses for exactly 1 cycle, subsequent entries are unaffected.
- Assert Reset mid-drain with 5 entries queued → fifo_level=0 and mem_en=0 immediately. After release no stale write appears; with VGA_FB_STATS_EN, frame_writes captures the commit count at the next vSync_n falling edge (e.g. 4 writes committed → frame_writes=4).
